// File: rtl/red_seq_unit_pkg.sv
// Shared types and constants for the nibble-serial byte-reduction unit.
// Also holds the step decoder that maps a step number to a byte select and a nibble index.
package red_seq_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned LastStep = 11;

  typedef enum logic [1:0] {
    SelALo = 2'd0,
    SelBLo = 2'd1,
    SelAHi = 2'd2,
    SelBHi = 2'd3
  } byte_sel_e;

  typedef struct packed {
    byte_sel_e  sel;
    logic [1:0] nib;
  } step_dec_t;

  // Three steps per byte: low nibble, high nibble, then carry into acc[11:8].
  function automatic step_dec_t step_decode(input int unsigned step);
    step_dec_t d;
    if (step < 3) begin
      d.sel = SelALo;
      d.nib = 2'(step);
    end else if (step < 6) begin
      d.sel = SelBLo;
      d.nib = 2'(step - 3);
    end else if (step < 9) begin
      d.sel = SelAHi;
      d.nib = 2'(step - 6);
    end else begin
      d.sel = SelBHi;
      d.nib = 2'(step - 9);
    end
    return d;
  endfunction

endpackage

// File: rtl/red_nib_slice.sv
// Combinational 4-bit carry-lookahead adder slice shared across all reduction steps.
module red_nib_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                (p[3] & p[2] & p[1] & p[0] & cin_i);

  assign sum_o  = p ^ c[3:0];
  assign cout_o = c[4];

endmodule

// File: rtl/red_seq_unit.sv
// Nibble-serial reduction: Sum = A[7:0] + B[7:0] + A[15:8] + B[15:8] over 12 cycles,
// using one shared 4-bit CLA slice, with ready/valid handshakes on both sides.
module red_seq_unit
  import red_seq_unit_pkg::*;
#(
  parameter bit          SEXT_OUT  = 1'b0,
  parameter int unsigned NIB_CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Sum,
  output logic        busy
);

  state_e               state_q, state_d;
  logic [11:0]          acc_q, acc_d;
  logic [NIB_CNT_W-1:0] step_q, step_d;
  logic                 carry_q, carry_d;
  logic [15:0]          opa_q, opa_d;
  logic [15:0]          opb_q, opb_d;

  step_dec_t  dec;
  logic [7:0] op_byte;
  logic [3:0] op_nib;
  logic [3:0] acc_nib;
  logic       slice_cin;
  logic [3:0] slice_sum;
  logic       slice_cout;

  always_comb begin
    dec = step_decode(32'(step_q));
    unique case (dec.sel)
      SelALo:  op_byte = opa_q[7:0];
      SelBLo:  op_byte = opb_q[7:0];
      SelAHi:  op_byte = opa_q[15:8];
      SelBHi:  op_byte = opb_q[15:8];
      default: op_byte = 8'h00;
    endcase
    unique case (dec.nib)
      2'd0: begin
        op_nib  = op_byte[3:0];
        acc_nib = acc_q[3:0];
      end
      2'd1: begin
        op_nib  = op_byte[7:4];
        acc_nib = acc_q[7:4];
      end
      default: begin
        op_nib  = 4'h0;
        acc_nib = acc_q[11:8];
      end
    endcase
    slice_cin = (dec.nib == 2'd0) ? 1'b0 : carry_q;
  end

  red_nib_slice u_slice (
    .a_i    (acc_nib),
    .b_i    (op_nib),
    .cin_i  (slice_cin),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opa_d   = A;
          opb_d   = B;
          acc_d   = 12'h000;
          step_d  = '0;
          carry_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        unique case (dec.nib)
          2'd0:    acc_d[3:0]  = slice_sum;
          2'd1:    acc_d[7:4]  = slice_sum;
          default: acc_d[11:8] = slice_sum;
        endcase
        // Carry only chains within one byte; the top-nibble step starts the next byte clean.
        carry_d = (dec.nib == 2'd2) ? 1'b0 : slice_cout;
        if (step_q == NIB_CNT_W'(LastStep)) begin
          state_d = StDone;
        end else begin
          step_d = step_q + NIB_CNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= 12'h000;
      step_q  <= '0;
      carry_q <= 1'b0;
      opa_q   <= 16'h0000;
      opb_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign Sum       = {SEXT_OUT ? {4{acc_q[11]}} : 4'h0, acc_q};

endmodule

// File: tb/tb_red_seq_unit.sv
// Scoreboarded bench for red_seq_unit: stimulus pushes expected sums, a negedge monitor
// pops and compares on every output handshake. Both SEXT_OUT settings run side by side.
module tb_red_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        in_ready0, out_valid0, busy0;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] sum0, sum1;

  int unsigned checks;
  int unsigned failures;
  logic [15:0] sb[$];

  red_seq_unit #(.SEXT_OUT(1'b0), .NIB_CNT_W(4)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .A         (A),
    .B         (B),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .Sum       (sum0),
    .busy      (busy0)
  );

  red_seq_unit #(.SEXT_OUT(1'b1), .NIB_CNT_W(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .A         (A),
    .B         (B),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .Sum       (sum1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] red_ref(input logic [15:0] a, input logic [15:0] b);
    return 16'(a[7:0]) + 16'(b[7:0]) + 16'(a[15:8]) + 16'(b[15:8]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output handshake must match the oldest expected sum.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(sum0), 32'hFFFF_FFFF);
      end else begin
        logic [15:0] exp;
        exp = sb.pop_front();
        check("sum_sext0", 32'(sum0), 32'(exp));
        check("sum_sext1", 32'(sum1), 32'(exp));
        check("valid_sext1", 32'(out_valid1), 32'd1);
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                        input logic [15:0] post_a, input logic [15:0] post_b,
                        input int hold_cycles);
    int lat;
    sb.push_back(exp);
    out_ready = (hold_cycles == 0);
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = post_a;
    B = post_b;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      tick();
      lat++;
      check("busy_during_op", 32'(busy0), 32'd1);
    end
    check("latency", 32'(lat), 32'd12);
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      check("hold_sum", 32'(sum0), 32'(exp));
      check("hold_valid", 32'(out_valid0), 32'd1);
      check("hold_in_ready", 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready0), 32'd1);
    check("idle_out_valid", 32'(out_valid0), 32'd0);
    check("idle_busy", 32'(busy0), 32'd0);
    check("idle_sum_held", 32'(sum0), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] va;
    logic [15:0] vb;
    int          waited;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 16'h0000;
    B         = 16'h0000;
    #2;
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_sum", 32'(sum0), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op(16'h0102, 16'h0304, 16'h000A, 16'h5555, 16'hAAAA, 0);
    run_op(16'hFFFF, 16'hFFFF, 16'h03FC, 16'h0000, 16'h0000, 0);
    run_op(16'h80F0, 16'h7F0F, 16'h01FE, 16'h1234, 16'h4321, 5);

    // Back-to-back: operands change every cycle, accepts only at 0, 14 and 28.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i <= 28; i++) begin
      va = {8'(i), 8'(i + 8'h11)};
      vb = {8'(8'hA0 ^ 8'(i)), 8'(8'h05 + 8'(i))};
      A = va;
      B = vb;
      check("b2b_in_ready", 32'(in_ready0), (i == 0 || i == 14 || i == 28) ? 32'd1 : 32'd0);
      if (i == 0 || i == 14 || i == 28) sb.push_back(red_ref(va, vb));
      tick();
    end
    in_valid = 1'b0;
    waited = 0;
    while (!in_ready0 && waited < 20) begin
      tick();
      waited++;
    end
    check("b2b_drain", 32'(in_ready0), 32'd1);

    // Reset pulse at step 6 discards the pending operation.
    A = 16'h1234;
    B = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(out_valid0), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready0), 32'd1);
    check("midrun_rst_busy", 32'(busy0), 32'd0);
    check("midrun_rst_sum", 32'(sum0), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(16'h0011, 16'h2200, 16'h0033, 16'h0000, 16'h0000, 0);

    run_op(16'h0001, 16'h0001, 16'h0002, 16'hFFFF, 16'hFFFF, 0);

    tick();
    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/red_seq_unit.md
Name: red_seq_unit

Overview:
- Multi-cycle, nibble-serial implementation of the RED (byte-reduction) operation.
- Result is the unsigned sum of the four bytes of A and B: A[7:0] + B[7:0] + A[15:8] + B[15:8].
- Uses one shared 4-bit carry-lookahead slice over 12 cycles, trading latency for area.
- Sits beside the ALU as an alternate RED path. Ready/valid on both sides, so the pipeline can stall on it.

Parameters:
- SEXT_OUT, 0: 0 means Sum[15:12] = 0. 1 means Sum[15:12] replicates acc[11]. Bit 11 is always 0 for legal sums, so both settings give the same value.
- NIB_CNT_W, 4: width of the step counter. Must be at least 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands A and B are valid.
- in_ready  out  1  unit can accept operands.
- A  in  16  operand A.
- B  in  16  operand B.
- out_valid  out  1  Sum is valid.
- out_ready  in  1  consumer takes Sum.
- Sum  out  16  reduction result.
- busy  out  1  high in the RUN or DONE state.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, Sum=0;
  - internal regs acc[11:0]=0, step=0, carry=0, opA/opB=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch A→opA and B→opB, clear acc, step and carry, go to RUN.
- RUN:
  - in_ready=0. Exactly 12 steps, numbered step=0..11.
  - Byte index k = step/3; nibble index n = step%3.
  - Byte order: k=0 opA[7:0], k=1 opB[7:0], k=2 opA[15:8], k=3 opB[15:8].
  - Operand nibble: n=0 → byte[3:0], n=1 → byte[7:4], n=2 → 4'h0.
  - Each step: acc[4n+3:4n] ← acc[4n+3:4n] + operand nibble + cin.
  - cin = 0 when n=0, otherwise the carry register. The carry register takes the slice carry-out; it is cleared when n=2.
  - After step 11 the FSM goes to DONE.
- DONE:
  - out_valid=1; Sum={SEXT_OUT ? {4{acc[11]}} : 4'h0, acc}.
  - Sum and out_valid stay stable until out_ready=1.
  - On out_ready the FSM returns to IDLE; out_valid drops and Sum holds its last value.
  - in_ready is 0 in DONE: there is no same-cycle accept. The next accept can happen 1 cycle after the handoff.
- Latency:
  - The accept edge is T0; out_valid=1 after edge T12. The minimum initiation interval is 14 cycles.
  - in_valid is ignored while not in IDLE; operand changes during RUN have no effect.
- Width: the maximum sum is 4×255=1020 (0x3FC), so acc never overflows 12 bits.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. A pending result is discarded and out_valid drops asynchronously.
- out_ready while not in DONE is ignored.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the constant LAST_STEP=11, and the byte-order select codes.
- One sub-module, red_nib_slice: a combinational 4-bit CLA taking a, b and cin and producing sum and cout. It is built from the team's existing cla_adder_4bit with generate/propagate combined into cout.
- FSM, counter and accumulator stay in the top module.

Test Plan:
- A=16'h0102, B=16'h0304, out_ready=1 → out_valid rises 12 cycles after accept; Sum=16'h000A; busy high throughout.
- A=16'hFFFF, B=16'hFFFF → Sum=16'h03FC, for both SEXT_OUT=0 and SEXT_OUT=1.
- A=16'h80F0, B=16'h7F0F, out_ready held 0 for 5 cycles after out_valid → Sum=16'h01FE stays stable and in_ready stays 0. Releasing out_ready gives IDLE the next cycle.
- Back-to-back: in_valid held 1 with A/B changing every cycle → the first operands are latched. A second accept occurs only after the DONE handoff, and its result corresponds to the operands present on that accept cycle.
- Reset pulse (rst_n=0 for 1 cycle) at step 6 → out_valid=0 and in_ready=1 immediately. A following op with A=16'h0011, B=16'h2200 yields Sum=16'h0033.
- Operand change mid-RUN: accept A=16'h0001, B=16'h0001, then drive A=16'hFFFF → Sum=16'h0002.
